fifo_unpacker: RTL and testbench

Downstream drain stage for the team's `fifo` block. It pops wide words from the FIFO through the FIFO's `deq`/`empty`/`data_out` interface. Each popped word is split into `LANES` narrow beats, which are presented on a valid/ready output stream with a last-beat marker. It is the width down-converter between the FIFO and any narrow consumer, and it never over-reads the FIFO.

---
 rtl/fifo_unpacker.sv | 105 ++++++++++
 tb/tb_fifo_unpacker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// Purpose: pops wide FIFO words and replays each one as LANES narrow beats with a last marker.
// Latency: first beat valid two cycles after the pop edge; LANES+1 cycles per word when unstalled.
// Backpressure: out_ready low holds the current beat; the next word is popped only on the final-beat handshake.
module fifo_unpacker #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int LANES     = IN_WIDTH / OUT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_deq,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic                  deq_d;
    logic [LW-1:0]         sel;
    logic [OUT_WIDTH-1:0]  lanes [LANES];

    // Slice the held word into beats once; the lane counter just picks one.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lanes[g] = word_q[g*OUT_WIDTH +: OUT_WIDTH];
    end

    // Beat order is a pure relabelling of the lane counter.
    assign sel       = MSB_FIRST ? (LAST_LANE - lane_q) : lane_q;
    assign out_data  = lanes[sel];
    assign out_valid = (state_q == S_SEND);
    assign out_last  = (state_q == S_SEND) && (lane_q == LAST_LANE);
    assign busy      = (state_q != S_IDLE);
    assign fifo_deq  = deq_d;

    // Next-state and pop decision; a pop in SEND is only allowed on the final-beat handshake.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        deq_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                deq_d = !fifo_empty;
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // FIFO read data is valid exactly one cycle after the pop edge.
                word_d  = fifo_data;
                lane_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                deq_d = (lane_q == LAST_LANE) && out_ready && !fifo_empty;
                if (out_ready) begin
                    if (lane_q != LAST_LANE) begin
                        lane_d = lane_q + LW'(1);
                    end else if (!fifo_empty) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Never request a pop while the block is held in reset.
        if (!reset) begin
            deq_d = 1'b0;
        end
    end

    // State, held word and lane counter; reset discards any partially sent word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Purpose: self-checking bench for fifo_unpacker (LSB-first and MSB-first instances on shared stimulus).
// Latency: checks pop-to-first-beat spacing and per-word cycle budget against a beat-stream model.
// Backpressure: drives directed and random out_ready patterns; every valid beat is checked for stability.
module tb_fifo_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [63:0] fifo_data;
    logic        out_ready;
    logic        fifo_deq0, fifo_deq1;
    logic        out_valid0, out_valid1;
    logic [15:0] out_data0, out_data1;
    logic        out_last0, out_last1;
    logic        busy0, busy1;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO contents and expected beat streams ({last, data}) for each beat order.
    logic [63:0] fq [$];
    logic [16:0] exp0 [$];
    logic [16:0] exp1 [$];

    int cyc = 0;
    int n_deq, n_beats, first_deq, first_valid, last_beat, n_deq_on_last, n_push;

    always #5 clk = ~clk;

    fifo_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_deq(fifo_deq0),
        .fifo_data(fifo_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_last(out_last0), .busy(busy0)
    );

    fifo_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_deq(fifo_deq1),
        .fifo_data(fifo_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        n_deq = 0; n_beats = 0; first_deq = -1; first_valid = -1;
        last_beat = -1; n_deq_on_last = 0;
    endtask

    // A word enters the FIFO; its beats are the word's 16-bit fields in either order.
    task automatic push(input logic [63:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        n_push++;
        for (int i = 0; i < 4; i++) begin
            exp0.push_back({i == 3, w[i*16 +: 16]});
            exp1.push_back({i == 3, w[(3-i)*16 +: 16]});
        end
    endtask

    // One clock: sample at negedge, then apply the FIFO pop just after the rising edge.
    task automatic cycle();
        logic d;
        logic hs;
        @(negedge clk);
        d  = fifo_deq0;
        hs = out_valid0 && out_ready;
        chk("deq_match", fifo_deq1, d);
        chk("valid_match", out_valid1, out_valid0);
        chk("busy_match", busy1, busy0);
        if (d) begin
            chk("deq_while_empty", fifo_empty, 1'b0);
            n_deq++;
            if (first_deq < 0) first_deq = cyc;
            if (busy0) begin
                chk("deq_with_unsent_beats", hs && out_last0, 1'b1);
                n_deq_on_last++;
            end
        end
        if (out_valid0) begin
            chk("beat_expected", exp0.size() != 0, 1'b1);
            if (exp0.size() != 0) begin
                chk("data_lsb", out_data0, exp0[0][15:0]);
                chk("last_lsb", out_last0, exp0[0][16]);
                chk("data_msb", out_data1, exp1[0][15:0]);
                chk("last_msb", out_last1, exp1[0][16]);
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) begin
                    void'(exp0.pop_front());
                    void'(exp1.pop_front());
                    n_beats++;
                    last_beat = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (d && fq.size() != 0) begin
            fifo_data  = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((busy0 || fq.size() != 0) && k < maxc) begin
            cycle();
            k++;
        end
        chk("drain_timeout", k < maxc, 1'b1);
    endtask

    initial begin
        logic [16:0] e;
        int k;
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        out_ready  = 1'b0;
        n_push     = 0;
        clr_stats();

        // Reset state, with a word already waiting: no pop while reset is low.
        #1;
        push(64'h0123_4567_89AB_CDEF);
        repeat (2) cycle();
        chk("rst_deq", fifo_deq0, 1'b0);
        chk("rst_valid", out_valid0, 1'b0);
        chk("rst_last", out_last0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_data", out_data0, 16'h0);
        chk("rst_no_pop", n_deq, 0);

        // Single word, both beat orders, ready high.
        out_ready = 1'b1;
        reset     = 1'b1;
        drain(40);
        chk("single_deq_count", n_deq, 1);
        chk("single_beats", n_beats, 4);
        chk("single_first_valid_lat", first_valid - first_deq, 2);
        chk("single_last_beat_cyc", last_beat - first_deq, 5);
        chk("single_exp_empty", exp0.size(), 0);

        // Back-to-back: three queued words.
        clr_stats();
        push(64'h1111_2222_3333_4444);
        push(64'hDEAD_BEEF_CAFE_F00D);
        push(64'h0F0F_A5A5_5A5A_F0F0);
        drain(80);
        chk("b2b_deq_count", n_deq, 3);
        chk("b2b_beats", n_beats, 12);
        chk("b2b_span", last_beat - first_deq, 15);
        chk("b2b_deq_on_last", n_deq_on_last, 2);

        // Backpressure: ready low for three cycles while beat 1 is presented.
        clr_stats();
        push(64'h0123_4567_89AB_CDEF);
        k = 0;
        while (n_beats < 1 && k < 20) begin cycle(); k++; end
        chk("bp_reach_beat1", n_beats, 1);
        out_ready = 1'b0;
        repeat (3) cycle();
        out_ready = 1'b1;
        drain(40);
        chk("bp_beats", n_beats, 4);
        chk("bp_span", last_beat - first_deq, 8);

        // Empty FIFO: nothing happens.
        clr_stats();
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("empty_deq", fifo_deq0, 1'b0);
            chk("empty_valid", out_valid0, 1'b0);
            chk("empty_busy", busy0, 1'b0);
        end

        // Reset mid-word after beat 1: remaining beats are dropped, next word starts fresh.
        clr_stats();
        push(64'hAAAA_BBBB_CCCC_DDDD);
        push(64'h1234_5678_9ABC_DEF0);
        k = 0;
        while (n_beats < 2 && k < 20) begin cycle(); k++; end
        chk("mid_reach_beat2", n_beats, 2);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid0, 1'b0);
        chk("mid_rst_last", out_last0, 1'b0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_deq", fifo_deq0, 1'b0);
        do begin e = exp0.pop_front(); void'(exp1.pop_front()); end while (!e[16]);
        repeat (2) cycle();
        reset = 1'b1;
        drain(40);
        chk("mid_deq_count", n_deq, 2);
        chk("mid_beats", n_beats, 6);
        chk("mid_exp_empty", exp0.size(), 0);

        // Random traffic and random backpressure.
        clr_stats();
        n_push = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 3) push({$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        drain(200);
        chk("rand_deq_count", n_deq, n_push);
        chk("rand_beats", n_beats, 4 * n_push);
        chk("rand_exp_empty", exp0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
